stream_pushr_n: RTL

- Parametrised successor to the single-value pushr primitive.
- Captures N scalar values per call, emits them on the output stream, then forwards the input stream element by element.
- One registered output stage.
- Sits among the stream primitives in primitives.v. Used where a compiled function prepends several constants or arguments to a stream.

---
 rtl/stream_pushr_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/stream_pushr_n.sv
// Pushes N captured scalar values onto an output stream, then forwards the input stream.
// The output element sits in a single register stage; a new call may preempt passthrough.
//   state | meaning
//   IDLE  | no call yet; waiting for the first request
//   EMIT  | loading captured slots into the output register, one per loadable cycle
//   PASS  | forwarding sIn elements to sOut; a new call may be accepted
module stream_pushr_n #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int ORDER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [N*WIDTH-1:0] dIn,
  input  logic [WIDTH-1:0]   sIn,
  input  logic               sIn_valid,
  output logic               sIn_ready,
  output logic [WIDTH-1:0]   sOut,
  output logic               sOut_valid,
  input  logic               sOut_ready
);

  localparam int IW = $clog2(N) + 1;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] FIRST_IDX = (ORDER == 0) ? '0 : IW'(N - 1);
  localparam logic [IW-1:0] LAST_IDX  = (ORDER == 0) ? IW'(N - 1) : '0;

  typedef enum logic [1:0] {IDLE, EMIT, PASS} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] slot_q [N];
  logic [WIDTH-1:0] slot_d [N];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;

  logic             loadable;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_data;

  assign loadable   = !sout_valid_q || sOut_ready;
  assign in_ready   = (state_q != EMIT) && !out_valid_q;
  assign accept     = in_valid && in_ready;
  assign sIn_ready  = (state_q == PASS) && loadable && sIn_valid;
  assign out_valid  = out_valid_q;
  assign sOut       = sout_q;
  assign sOut_valid = sout_valid_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    load_data   = sout_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: ;
      EMIT: begin
        if (loadable) begin
          load      = 1'b1;
          load_data = slot_q[idx_q[SW-1:0]];
          if (idx_q == LAST_IDX) state_d = PASS;
          else if (ORDER == 0)   idx_d = idx_q + IW'(1);
          else                   idx_d = idx_q - IW'(1);
        end
      end
      PASS: begin
        if (sIn_ready) begin
          load      = 1'b1;
          load_data = sIn;
        end
      end
      default: state_d = IDLE;
    endcase

    // A call in PASS still lets this cycle's sIn transfer complete before the slots.
    if (accept) begin
      for (int k = 0; k < N; k++) slot_d[k] = dIn[k*WIDTH +: WIDTH];
      idx_d       = FIRST_IDX;
      state_d     = EMIT;
      out_valid_d = 1'b1;
    end

    sout_d       = load ? load_data : sout_q;
    sout_valid_d = load ? 1'b1 : (sOut_ready ? 1'b0 : sout_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      sout_q       <= '0;
      sout_valid_q <= 1'b0;
      for (int k = 0; k < N; k++) slot_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      for (int k = 0; k < N; k++) slot_q[k] <= slot_d[k];
    end
  end

endmodule
